// File: rtl/mux4_rr_sequencer.sv
// rtl/mux4_rr_sequencer.sv - round-robin select sequencer for a 4-input registered mux stage
module mux4_rr_sequencer #(
  parameter int BURST = 2,
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] select,
  output logic [3:0] grant,
  output logic       out_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] burst_cnt, burst_d;

  logic             advance;
  logic             cont;
  logic             found;
  logic [1:0]       hit;
  logic [1:0]       idx;

  // A held beat blocks progress only while the downstream is not taking it.
  assign advance   = !vld_q || out_ready;
  assign grant     = advance ? gnt_q : 4'b0000;
  assign select    = sel_q;
  assign out_valid = vld_q;
  assign busy      = (|gnt_q) || vld_q;

  // Round-robin search starting one past the current select, wrapping back to it last.
  always_comb begin
    found = 1'b0;
    hit   = sel_q;
    idx   = sel_q;
    for (int k = 1; k <= 4; k++) begin
      idx = sel_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        hit   = idx;
      end
    end
  end

  // Next-state: continue the current burst, rotate to the next requester, or go quiet.
  always_comb begin
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    burst_d = burst_cnt;
    cont    = (|gnt_q) && req[sel_q] && (burst_cnt < BURST_LAST);
    if (advance) begin
      vld_d = |gnt_q;
      if (cont) begin
        burst_d = burst_cnt + CNT_W'(1);
      end else if (found) begin
        sel_d   = hit;
        gnt_d   = 4'b0001 << hit;
        burst_d = '0;
      end else begin
        gnt_d   = 4'b0000;
        burst_d = '0;
      end
    end
  end

  // State registers; reset discards any in-flight beat immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      vld_q     <= 1'b0;
      burst_cnt <= '0;
    end else begin
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      vld_q     <= vld_d;
      burst_cnt <= burst_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// tb/tb_mux4_rr_sequencer.sv - directed self-checking bench for mux4_rr_sequencer
module tb_mux4_rr_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;

  logic [1:0] sel1, sel2, sel4;
  logic [3:0] gnt1, gnt2, gnt4;
  logic       vld1, vld2, vld4;
  logic       busy1, busy2, busy4;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] rr_seq [9];
  logic [1:0] b1_seq [4];

  always #5 clock = ~clock;

  mux4_rr_sequencer #(.BURST(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .req(req), .out_ready(out_ready),
    .select(sel1), .grant(gnt1), .out_valid(vld1), .busy(busy1)
  );

  mux4_rr_sequencer #(.BURST(2), .CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .req(req), .out_ready(out_ready),
    .select(sel2), .grant(gnt2), .out_valid(vld2), .busy(busy2)
  );

  mux4_rr_sequencer #(.BURST(4), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .req(req), .out_ready(out_ready),
    .select(sel4), .grant(gnt4), .out_valid(vld4), .busy(busy4)
  );

  task automatic chk(input string tag,
                     input logic [1:0] so, input logic [3:0] go, input logic vo, input logic bo,
                     input logic [1:0] se, input logic [3:0] ge, input logic ve, input logic be);
    vectors++;
    assert ({so, go, vo, bo} === {se, ge, ve, be}) else begin
      miscompares++;
      $error("FAIL %s: got sel=%0d grant=%b valid=%b busy=%b, expected sel=%0d grant=%b valid=%b busy=%b",
             tag, so, go, vo, bo, se, ge, ve, be);
    end
  endtask

  task automatic c1(input string tag, input logic [1:0] se, input logic [3:0] ge, input logic ve, input logic be);
    chk(tag, sel1, gnt1, vld1, busy1, se, ge, ve, be);
  endtask

  task automatic c2(input string tag, input logic [1:0] se, input logic [3:0] ge, input logic ve, input logic be);
    chk(tag, sel2, gnt2, vld2, busy2, se, ge, ve, be);
  endtask

  task automatic c4(input string tag, input logic [1:0] se, input logic [3:0] ge, input logic ve, input logic be);
    chk(tag, sel4, gnt4, vld4, busy4, se, ge, ve, be);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    rr_seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
    b1_seq = '{2'd1, 2'd3, 2'd1, 2'd3};

    // reset then idle
    reset     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    repeat (3) tick();
    c2("reset_hold", 2'd0, 4'b0000, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    c2("idle_after_release", 2'd0, 4'b0000, 1'b0, 1'b0);

    // single source keeps winning via the wrap-around search
    req       = 4'b0100;
    out_ready = 1'b1;
    tick();
    c2("single_c1", 2'd2, 4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      c2("single_stream", 2'd2, 4'b0100, 1'b1, 1'b1);
    end

    // drain: requester leaves, last beat still shows valid
    req = 4'b0000;
    tick();
    c2("drain", 2'd2, 4'b0000, 1'b1, 1'b1);
    tick();
    c2("drain_idle", 2'd2, 4'b0000, 1'b0, 1'b0);

    // round robin, all requesting, bursts of two
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      c2("round_robin", rr_seq[i], 4'b0001 << rr_seq[i], (i > 0), 1'b1);
    end

    // backpressure with req changes during the stall
    do_reset();
    req = 4'b0011;
    tick();
    c2("bp_fill", 2'd1, 4'b0010, 1'b0, 1'b1);
    tick();
    c2("bp_stream", 2'd1, 4'b0010, 1'b1, 1'b1);
    out_ready = 1'b0;
    #1;
    c2("bp_grant_drop", 2'd1, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) req = 4'b1100;
      tick();
      c2("bp_stall", 2'd1, 4'b0000, 1'b1, 1'b1);
    end
    req       = 4'b0011;
    out_ready = 1'b1;
    #1;
    c2("bp_resume", 2'd1, 4'b0010, 1'b1, 1'b1);
    tick();
    c2("bp_rotate0", 2'd0, 4'b0001, 1'b1, 1'b1);
    tick();
    c2("bp_hold0", 2'd0, 4'b0001, 1'b1, 1'b1);
    tick();
    c2("bp_rotate1", 2'd1, 4'b0010, 1'b1, 1'b1);

    // drop mid-burst with BURST=4
    do_reset();
    req = 4'b0110;
    tick();
    c4("drop_first_grant", 2'd1, 4'b0010, 1'b0, 1'b1);
    req = 4'b0100;
    tick();
    c4("drop_moves_to_2", 2'd2, 4'b0100, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      c4("drop_burst4", 2'd2, 4'b0100, 1'b1, 1'b1);
    end

    // BURST=1 is pure per-beat round robin
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      c1("burst1_rr", b1_seq[i], 4'b0001 << b1_seq[i], (i > 0), 1'b1);
    end

    // asynchronous reset in the middle of a stream
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    c2("async_pre", 2'd1, 4'b0010, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    c2("async_reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    tick();
    c2("async_restart", 2'd1, 4'b0010, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
